// File: rtl/hud_pkg.sv
// Shared types and constants for the HUD number overlay: conversion FSM states,
// default transparent colour, glyph count of the number ROM and a 10^n-1 helper.
package hud_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } hud_conv_state_t;

  localparam logic [23:0] KEY_COLOR_DEFAULT = 24'hee35ff;
  localparam int          GLYPHS_PER_ROM    = 10;

  // Largest value that fits in n decimal digits (valid for n <= 9).
  function automatic int unsigned max_decimal(input int unsigned n);
    int unsigned p;
    p = 32'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/hud_number_overlay_if.sv
// Bundle of the game-state, raster and glyph-ROM signals of one HUD number field.
// master = surrounding video logic, slave = hud_number_overlay.
interface hud_number_overlay_if #(
  parameter int VALUE_W = 10,
  parameter int ADDR_W  = 12
);
  logic               frame_start;
  logic [VALUE_W-1:0] value;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic [ADDR_W-1:0]  glyph_addr;
  logic [23:0]        glyph_data;
  logic               overlay_on;
  logic [23:0]        overlay_rgb;
  logic               busy;
  logic               digits_valid;

  modport master (
    output frame_start, value, DrawX, DrawY, glyph_data,
    input  glyph_addr, overlay_on, overlay_rgb, busy, digits_valid
  );

  modport slave (
    input  frame_start, value, DrawX, DrawY, glyph_data,
    output glyph_addr, overlay_on, overlay_rgb, busy, digits_valid
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one conversion per frame_start, saturating
// at 10^NUM_DIGITS-1, VALUE_W shift cycles followed by one commit cycle.
module bin2bcd_seq
  import hud_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_start,
  input  logic [VALUE_W-1:0]         value,
  output logic                       busy,
  output logic                       digits_valid,
  output logic                       commit,
  output logic [NUM_DIGITS-1:0][3:0] bcd
);

  localparam int unsigned       MAX_VAL  = max_decimal(NUM_DIGITS);
  localparam int                CNT_W    = $clog2(VALUE_W + 1);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(VALUE_W);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  hud_conv_state_t            state_q, state_d;
  logic [VALUE_W-1:0]         op_q, op_d;
  logic [NUM_DIGITS-1:0][3:0] bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       busy_q, busy_d;
  logic                       dv_q, dv_d;
  logic                       sat;

  assign sat          = (32'(value) > MAX_VAL);
  assign busy         = busy_q;
  assign digits_valid = dv_q;
  assign commit       = (state_q == COMMIT);
  assign bcd          = bcd_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dv_d    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[i] = (bcd_q[i] >= 4'd5) ? (bcd_q[i] + 4'd3) : bcd_q[i];
    end
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = SHIFT;
          op_d    = sat ? VALUE_W'(MAX_VAL) : value;
          bcd_d   = '0;
          cnt_d   = CNT_INIT;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        {bcd_d, op_d} = {bcd_adj, op_q} << 1;
        cnt_d         = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = COMMIT;
        end else begin
          state_d = SHIFT;
        end
      end
      COMMIT: begin
        dv_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
    end
  end

endmodule

// File: rtl/hud_number_overlay.sv
// N-digit decimal HUD overlay: digit register plus a 3-stage pixel pipeline into
// the shared number glyph ROM. Optional macro: HUD_LEADING_ZERO_BLANK_EN.
module hud_number_overlay
  import hud_pkg::*;
#(
  parameter int          NUM_DIGITS = 3,
  parameter int          VALUE_W    = 10,
  parameter int          GLYPH_SIZE = 16,
  parameter int          ORIGIN_X   = 16,
  parameter int          ORIGIN_Y   = 16,
  parameter logic [23:0] KEY_COLOR  = KEY_COLOR_DEFAULT
) (
  input logic           Clk,
  input logic           Reset_n,
  hud_number_overlay_if.slave bus
);

  localparam int          LOG2G  = $clog2(GLYPH_SIZE);
  localparam int          ADDR_W = $clog2(GLYPHS_PER_ROM * GLYPH_SIZE * GLYPH_SIZE);
  localparam logic [10:0] X_LO   = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI   = 11'(ORIGIN_X + NUM_DIGITS * GLYPH_SIZE);
  localparam logic [10:0] Y_LO   = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI   = 11'(ORIGIN_Y + GLYPH_SIZE);

  logic                       commit_s;
  logic [NUM_DIGITS-1:0][3:0] bcd_s;
  logic [NUM_DIGITS-1:0][3:0] digit_q, digit_d;  // index = screen slot

  bin2bcd_seq #(
    .NUM_DIGITS (NUM_DIGITS),
    .VALUE_W    (VALUE_W)
  ) u_conv (
    .clk          (Clk),
    .rst_n        (Reset_n),
    .frame_start  (bus.frame_start),
    .value        (bus.value),
    .busy         (bus.busy),
    .digits_valid (bus.digits_valid),
    .commit       (commit_s),
    .bcd          (bcd_s)
  );

  // Slot 0 is leftmost, so it takes the most significant BCD nibble.
  always_comb begin
    digit_d = digit_q;
    if (commit_s) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        digit_d[i] = bcd_s[NUM_DIGITS-1-i];
      end
    end else begin
      digit_d = digit_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) digit_q <= '0;
    else          digit_q <= digit_d;
  end

`ifdef HUD_LEADING_ZERO_BLANK_EN
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = NUM_DIGITS'((1 << (NUM_DIGITS - 1)) - 1);
  logic [NUM_DIGITS-1:0] blank_q, blank_d;

  function automatic logic [NUM_DIGITS-1:0] lead_mask(input logic [NUM_DIGITS-1:0][3:0] d);
    logic [NUM_DIGITS-1:0] m;
    logic                  lead;
    m    = '0;
    lead = 1'b1;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      if (lead && (d[i] == 4'd0)) m[i] = 1'b1;
      else                        lead = 1'b0;
    end
    return m;
  endfunction

  always_comb begin
    blank_d = blank_q;
    if (commit_s) blank_d = lead_mask(digit_d);
    else          blank_d = blank_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) blank_q <= BLANK_RST;
    else          blank_q <= blank_d;
  end
`else
  logic [NUM_DIGITS-1:0] blank_q;
  assign blank_q = '0;
`endif

  logic [10:0]       x_s, y_s, dx_s, slot_s;
  logic [LOG2G-1:0]  lx_s, ly_s;
  logic [3:0]        sel_digit_s;
  logic              sel_blank_s, in_box_s;
  logic              hit_q, hit_d, hit_d2_q, hit_d2_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              on_q, on_d;
  logic [23:0]       rgb_q, rgb_d;

  // Comparisons at 11 bits so the right edge of the box cannot wrap.
  always_comb begin
    x_s         = {1'b0, bus.DrawX};
    y_s         = {1'b0, bus.DrawY};
    in_box_s    = (x_s >= X_LO) && (x_s < X_HI) && (y_s >= Y_LO) && (y_s < Y_HI);
    dx_s        = x_s - X_LO;
    slot_s      = dx_s >> LOG2G;
    lx_s        = bus.DrawX[LOG2G-1:0];
    ly_s        = bus.DrawY[LOG2G-1:0];
    sel_digit_s = 4'd0;
    sel_blank_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_digit_s = (slot_s == 11'(i)) ? digit_q[i] : sel_digit_s;
      sel_blank_s = (slot_s == 11'(i)) ? blank_q[i] : sel_blank_s;
    end
    hit_d    = in_box_s & ~sel_blank_s;
    addr_d   = hit_d ? ADDR_W'({sel_digit_s, ly_s, lx_s}) : '0;
    hit_d2_d = hit_q;
    on_d     = hit_d2_q && (bus.glyph_data != KEY_COLOR);
    rgb_d    = on_d ? bus.glyph_data : 24'h000000;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      hit_q    <= 1'b0;
      addr_q   <= '0;
      hit_d2_q <= 1'b0;
      on_q     <= 1'b0;
      rgb_q    <= 24'h000000;
    end else begin
      hit_q    <= hit_d;
      addr_q   <= addr_d;
      hit_d2_q <= hit_d2_d;
      on_q     <= on_d;
      rgb_q    <= rgb_d;
    end
  end

  assign bus.glyph_addr  = addr_q;
  assign bus.overlay_on  = on_q;
  assign bus.overlay_rgb = rgb_q;

endmodule
